// File: rtl/bram_port_arbiter_pkg.sv
// Shared types, constants and the round-robin pick function for bram_port_arbiter.
// The optional grant-counter feature is enabled with BRAM_ARB_STATS_EN.
package bram_arb_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned MAX_REQ = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // One-hot grant: first asserted request found scanning from ptr upward, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input int unsigned        ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] gnt;
    int unsigned        k;
    gnt = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      k = (ptr + i) % n;
      if ((i < n) && (gnt == '0) && req[k]) begin
        gnt[k] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester + BRAM bus bundle for bram_port_arbiter; slave modport faces the arbiter.
// Stats ports exist only when BRAM_ARB_STATS_EN is defined.
interface bram_port_arbiter_if
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            i_wr_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_wr_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_wr_data;
  logic [NUM_REQ-1:0]            o_wr_gnt;
  logic [NUM_REQ-1:0]            i_rd_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_rd_addr;
  logic [NUM_REQ-1:0]            o_rd_gnt;
  logic                          o_rd_rsp_valid;
  logic [ID_W-1:0]               o_rd_rsp_id;
  logic [DATA_WIDTH-1:0]         o_rd_data;
  logic                          o_bram_wr_en;
  logic [ADDR_WIDTH-1:0]         o_bram_wr_addr;
  logic [DATA_WIDTH-1:0]         o_bram_wr_data;
  logic [ADDR_WIDTH-1:0]         o_bram_rd_addr;
  logic [DATA_WIDTH-1:0]         i_bram_rd_data;
`ifdef BRAM_ARB_STATS_EN
  logic                          i_stat_clr;
  logic [NUM_REQ*CNT_W-1:0]      o_wr_cnt;
  logic [NUM_REQ*CNT_W-1:0]      o_rd_cnt;
`endif

  modport slave (
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_bram_rd_data,
    output o_wr_gnt, o_rd_gnt, o_rd_rsp_valid, o_rd_rsp_id, o_rd_data,
    output o_bram_wr_en, o_bram_wr_addr, o_bram_wr_data, o_bram_rd_addr
`ifdef BRAM_ARB_STATS_EN
    , input i_stat_clr
    , output o_wr_cnt, o_rd_cnt
`endif
  );

  modport master (
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_bram_rd_data,
    input  o_wr_gnt, o_rd_gnt, o_rd_rsp_valid, o_rd_rsp_id, o_rd_data,
    input  o_bram_wr_en, o_bram_wr_addr, o_bram_wr_data, o_bram_rd_addr
`ifdef BRAM_ARB_STATS_EN
    , output i_stat_clr
    , input o_wr_cnt, o_rd_cnt
`endif
  );

endinterface

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from a registered search pointer.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic [ID_W-1:0]    ptr_q;
  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] gnt_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = i_req;
    gnt_ext              = rr_pick(req_ext, 32'(ptr_q), NUM_REQ);
    o_gnt                = gnt_ext[NUM_REQ-1:0];
    o_any                = |gnt_ext;
  end

  always_comb begin
    o_idx = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (o_gnt[r]) begin
        o_idx = ID_W'(r);
      end
    end
  end

  // Pointer moves just past the winner so the winner becomes lowest priority next.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (o_any) begin
      ptr_q <= (o_idx == ID_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one dual-port BRAM between NUM_REQ requesters with independent write/read
// round-robin arbiters. Optional per-requester grant counters under BRAM_ARB_STATS_EN.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                 i_clk_wr,
  input  logic                 i_rst_n,
  bram_port_arbiter_if.slave   bus
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]    wr_gnt;
  logic [NUM_REQ-1:0]    rd_gnt;
  logic [ID_W-1:0]       wr_idx;
  logic [ID_W-1:0]       rd_idx;
  logic                  wr_any;
  logic                  rd_any;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_nxt;
  logic                  rsp_valid_q;
  logic [ID_W-1:0]       rsp_id_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_wr_arb (
    .i_clk   (i_clk_wr),
    .i_rst_n (i_rst_n),
    .i_req   (bus.i_wr_req),
    .o_gnt   (wr_gnt),
    .o_idx   (wr_idx),
    .o_any   (wr_any)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rd_arb (
    .i_clk   (i_clk_wr),
    .i_rst_n (i_rst_n),
    .i_req   (bus.i_rd_req),
    .o_gnt   (rd_gnt),
    .o_idx   (rd_idx),
    .o_any   (rd_any)
  );

  assign bus.o_wr_gnt = wr_gnt;
  assign bus.o_rd_gnt = rd_gnt;

  always_comb begin
    bus.o_bram_wr_en   = wr_any;
    bus.o_bram_wr_addr = '0;
    bus.o_bram_wr_data = '0;
    if (wr_any) begin
      bus.o_bram_wr_addr = bus.i_wr_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
      bus.o_bram_wr_data = bus.i_wr_data[wr_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Read address holds its last value when idle so the BRAM output stays stable.
  always_comb begin
    rd_addr_nxt = rd_addr_q;
    if (rd_any) begin
      rd_addr_nxt = bus.i_rd_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rd_addr_q   <= rd_addr_nxt;
      rsp_valid_q <= rd_any;
      rsp_id_q    <= rd_idx;
    end
  end

  assign bus.o_bram_rd_addr = rd_addr_nxt;
  assign bus.o_rd_rsp_valid = rsp_valid_q;
  assign bus.o_rd_rsp_id    = rsp_id_q;
  assign bus.o_rd_data      = bus.i_bram_rd_data;

`ifdef BRAM_ARB_STATS_EN
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_stats
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] rd_cnt_q;

    // Clear has priority over a grant in the same cycle; counts saturate.
    always_ff @(posedge i_clk_wr or negedge i_rst_n) begin
      if (!i_rst_n) begin
        wr_cnt_q <= '0;
        rd_cnt_q <= '0;
      end else if (bus.i_stat_clr) begin
        wr_cnt_q <= '0;
        rd_cnt_q <= '0;
      end else begin
        if (wr_gnt[r] && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 1'b1;
        if (rd_gnt[r] && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
      end
    end

    assign bus.o_wr_cnt[r*CNT_W +: CNT_W] = wr_cnt_q;
    assign bus.o_rd_cnt[r*CNT_W +: CNT_W] = rd_cnt_q;
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter (NUM_REQ=2): reference model of round-robin arbitration and
// a BRAM shadow, plus directed scenarios with literal expectations. Stats with BRAM_ARB_STATS_EN.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  bram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk_wr (clk),
    .i_rst_n  (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // External BRAM: registered read, read-before-write, output register resets to 0.
  logic [DW-1:0] mem [256] = '{default: 8'h00};
  logic [DW-1:0] bram_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bram_q <= '0;
    else begin
      bram_q <= mem[bus.o_bram_rd_addr];
      if (bus.o_bram_wr_en) mem[bus.o_bram_wr_addr] <= bus.o_bram_wr_data;
    end
  end
  assign bus.i_bram_rd_data = bram_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int            m_wptr = 0, m_rptr = 0, m_id = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [AW-1:0] m_raddr = '0;
  logic [DW-1:0] shadow [256] = '{default: 8'h00};
  int            m_wcnt [NR];
  int            m_rcnt [NR];

  function automatic int pick(input logic [NR-1:0] req, input int ptr);
    for (int i = 0; i < int'(NR); i++) begin
      if (req[(ptr + i) % NR]) return (ptr + i) % NR;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int wg, rg;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    if (!rst_n) begin
      m_wptr = 0; m_rptr = 0; m_valid = 1'b0; m_raddr = '0; m_id = 0;
      for (int r = 0; r < int'(NR); r++) begin m_wcnt[r] = 0; m_rcnt[r] = 0; end
      check("rst_rsp_valid", 32'(bus.o_rd_rsp_valid), 0);
      check("rst_rsp_id", 32'(bus.o_rd_rsp_id), 0);
      check("rst_rd_addr", 32'(bus.o_bram_rd_addr), 0);
      check("rst_wr_en", 32'(bus.o_bram_wr_en), 0);
    end else begin
      wg = pick(bus.i_wr_req, m_wptr);
      rg = pick(bus.i_rd_req, m_rptr);
      wa = '0; wd = '0; ra = m_raddr;
      if (wg >= 0) begin
        wa = bus.i_wr_addr[wg*AW +: AW];
        wd = bus.i_wr_data[wg*DW +: DW];
      end
      if (rg >= 0) ra = bus.i_rd_addr[rg*AW +: AW];
      check("m_wr_gnt", 32'(bus.o_wr_gnt), (wg < 0) ? 0 : (1 << wg));
      check("m_wr_en", 32'(bus.o_bram_wr_en), (wg >= 0) ? 1 : 0);
      check("m_wr_addr", 32'(bus.o_bram_wr_addr), 32'(wa));
      check("m_wr_data", 32'(bus.o_bram_wr_data), 32'(wd));
      check("m_rd_gnt", 32'(bus.o_rd_gnt), (rg < 0) ? 0 : (1 << rg));
      check("m_rd_addr", 32'(bus.o_bram_rd_addr), 32'(ra));
      check("m_rsp_valid", 32'(bus.o_rd_rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check("m_rsp_id", 32'(bus.o_rd_rsp_id), m_id);
        check("m_rsp_data", 32'(bus.o_rd_data), 32'(m_data));
      end
`ifdef BRAM_ARB_STATS_EN
      for (int r = 0; r < int'(NR); r++) begin
        check("m_wr_cnt", 32'(bus.o_wr_cnt[r*CNT_W +: CNT_W]), m_wcnt[r]);
        check("m_rd_cnt", 32'(bus.o_rd_cnt[r*CNT_W +: CNT_W]), m_rcnt[r]);
        if (bus.i_stat_clr) begin m_wcnt[r] = 0; m_rcnt[r] = 0; end
        else begin
          if (wg == r && m_wcnt[r] < 65535) m_wcnt[r]++;
          if (rg == r && m_rcnt[r] < 65535) m_rcnt[r]++;
        end
      end
`endif
      // state seen after the coming edge; read sees contents before this cycle's write
      m_valid = (rg >= 0);
      if (rg >= 0) begin m_id = rg; m_rptr = (rg + 1) % NR; end
      m_data  = shadow[ra];
      m_raddr = ra;
      if (wg >= 0) begin shadow[wa] = wd; m_wptr = (wg + 1) % NR; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_wr(input int r, input logic req, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_wr_req[r] = req;
    bus.i_wr_addr[r*AW +: AW] = a;
    bus.i_wr_data[r*DW +: DW] = d;
  endtask

  task automatic set_rd(input int r, input logic req, input logic [AW-1:0] a);
    bus.i_rd_req[r] = req;
    bus.i_rd_addr[r*AW +: AW] = a;
  endtask

  task automatic idle();
    bus.i_wr_req = '0;
    bus.i_rd_req = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [1:0] wreq; logic [1:0] rreq;
    logic [7:0] wa0; logic [7:0] wd0; logic [7:0] wa1; logic [7:0] wd1;
    logic [7:0] ra0; logic [7:0] ra1;
  } vec_t;

  vec_t vecs [8] = '{
    '{2'b11, 2'b00, 8'h50, 8'h01, 8'h51, 8'h02, 8'h00, 8'h00},
    '{2'b11, 2'b11, 8'h50, 8'h03, 8'h51, 8'h04, 8'h50, 8'h51},
    '{2'b10, 2'b11, 8'h00, 8'h00, 8'h52, 8'h05, 8'h51, 8'h52},
    '{2'b01, 2'b01, 8'h52, 8'h06, 8'h00, 8'h00, 8'h52, 8'h00},
    '{2'b00, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h50},
    '{2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{2'b11, 2'b10, 8'hFF, 8'hEE, 8'h00, 8'h77, 8'h00, 8'hFF},
    '{2'b00, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}
  };

  logic [1:0] t2_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic       t3_id  [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] t3_d   [3] = '{8'h11, 8'h22, 8'h11};

  initial begin
    bus.i_wr_req = '0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_rd_req = '0; bus.i_rd_addr = '0;
`ifdef BRAM_ARB_STATS_EN
    bus.i_stat_clr = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;

    // single write, then read back by the other requester
    set_wr(0, 1'b1, 8'h10, 8'hA5);
    @(negedge clk);
    check("t1_wr_gnt", 32'(bus.o_wr_gnt), 32'h1);
    check("t1_wr_en", 32'(bus.o_bram_wr_en), 32'h1);
    check("t1_wr_addr", 32'(bus.o_bram_wr_addr), 32'h10);
    check("t1_wr_data", 32'(bus.o_bram_wr_data), 32'hA5);
    step(); set_wr(0, 1'b0, 8'h00, 8'h00); set_rd(1, 1'b1, 8'h10);
    @(negedge clk);
    check("t1_rd_gnt", 32'(bus.o_rd_gnt), 32'h2);
    step(); set_rd(1, 1'b0, 8'h00);
    @(negedge clk);
    check("t1_rsp_valid", 32'(bus.o_rd_rsp_valid), 32'h1);
    check("t1_rsp_id", 32'(bus.o_rd_rsp_id), 32'h1);
    check("t1_rsp_data", 32'(bus.o_rd_data), 32'hA5);
    step();

    // both writers contend on one address
    do_reset();
    set_wr(0, 1'b1, 8'h30, 8'h0A); set_wr(1, 1'b1, 8'h30, 8'h0B);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t2_wr_gnt%0d", i), 32'(bus.o_wr_gnt), 32'(t2_gnt[i]));
      step();
    end
    idle(); set_rd(0, 1'b1, 8'h30);
    step(); idle();
    @(negedge clk);
    check("t2_last_writer", 32'(bus.o_rd_data), 32'h0B);
    step();

    // preload and back-to-back reads from both requesters
    do_reset();
    set_wr(0, 1'b1, 8'h01, 8'h11); step();
    set_wr(0, 1'b1, 8'h02, 8'h22); step();
    idle();
    set_rd(0, 1'b1, 8'h01); set_rd(1, 1'b1, 8'h02);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) idle();
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("t3_valid%0d", i), 32'(bus.o_rd_rsp_valid), 32'h1);
        check($sformatf("t3_id%0d", i), 32'(bus.o_rd_rsp_id), 32'(t3_id[i-1]));
        check($sformatf("t3_data%0d", i), 32'(bus.o_rd_data), 32'(t3_d[i-1]));
      end
      step();
    end

    // same-cycle write and read of one address returns old contents
    set_wr(0, 1'b1, 8'h20, 8'h5A); set_rd(1, 1'b1, 8'h20);
    step(); set_wr(0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("t4_old", 32'(bus.o_rd_data), 32'h00);
    step(); idle();
    @(negedge clk);
    check("t4_new", 32'(bus.o_rd_data), 32'h5A);
    step();

    // reset right after a read grant drops the response and rewinds pointers
    set_rd(0, 1'b1, 8'h01);
    @(negedge clk);
    check("t5_rd_gnt", 32'(bus.o_rd_gnt), 32'h1);
    step(); idle(); rst_n = 1'b0;
    @(negedge clk);
    check("t5_flushed", 32'(bus.o_rd_rsp_valid), 32'h0);
    step(); rst_n = 1'b1;
    set_wr(0, 1'b1, 8'h60, 8'hC1); set_wr(1, 1'b1, 8'h61, 8'hC2);
    set_rd(0, 1'b1, 8'h01); set_rd(1, 1'b1, 8'h02);
    @(negedge clk);
    check("t5_wr_first", 32'(bus.o_wr_gnt), 32'h1);
    check("t5_rd_first", 32'(bus.o_rd_gnt), 32'h1);
    check("t5_no_rsp", 32'(bus.o_rd_rsp_valid), 32'h0);
    step(); idle(); step();

    // directed vector table, checked by the model
    for (int v = 0; v < 8; v++) begin
      bus.i_wr_req = vecs[v].wreq; bus.i_rd_req = vecs[v].rreq;
      bus.i_wr_addr = {vecs[v].wa1, vecs[v].wa0};
      bus.i_wr_data = {vecs[v].wd1, vecs[v].wd0};
      bus.i_rd_addr = {vecs[v].ra1, vecs[v].ra0};
      step();
    end
    idle(); step(); step();

`ifdef BRAM_ARB_STATS_EN
    do_reset();
    set_wr(0, 1'b1, 8'h70, 8'h01); step(); step(); step();
    set_wr(0, 1'b0, 8'h00, 8'h00); set_wr(1, 1'b1, 8'h71, 8'h02); step();
    idle();
    @(negedge clk);
    check("t6_wr_cnt", 32'(bus.o_wr_cnt), 32'h0001_0003);
    set_wr(0, 1'b1, 8'h72, 8'h03); set_rd(1, 1'b1, 8'h72); bus.i_stat_clr = 1'b1;
    step(); idle(); bus.i_stat_clr = 1'b0;
    @(negedge clk);
    check("t6_wr_clr", 32'(bus.o_wr_cnt), 32'h0);
    check("t6_rd_clr", 32'(bus.o_rd_cnt), 32'h0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timed out");
  end

endmodule
